// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Lets the instruction cache (I) and the data cache (D) share one slow
//   memory. One requester is granted at a time with round-robin on ties.
//   The granted port's read/write handshake is forwarded combinationally to
//   the memory, and the memory's ready pulse is steered back to that port
//   only. Per-port saturating counters record completed transactions.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_read_I / mem_write_I      I-cache request levels (held until ready)
//   mem_addr_I / mem_wdata_I      I-cache line address / write data
//   mem_rdata_I / mem_ready_I     read data / completion pulse to I-cache
//   mem_*_D                       same set of signals for the D-cache
//   mem_read / mem_write          request to the slow memory
//   mem_addr / mem_wdata          address / write data to the slow memory
//   mem_rdata / mem_ready         read data / completion pulse from memory
//   grant_cnt_I / grant_cnt_D     completed transactions, saturate at 16'hFFFF
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [DATA_W-1:0] mem_wdata_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  // D-cache side
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  // Slow memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Performance counters
  output logic [15:0]       grant_cnt_I,
  output logic [15:0]       grant_cnt_D
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // Saturating increment used by both grant counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  state_t      state_q, state_d;
  // 0: I-cache was served last, 1: D-cache was served last.
  logic        last_q, last_d;
  logic [15:0] cnt_i_q, cnt_i_d;
  logic [15:0] cnt_d_q, cnt_d_d;

  logic        req_i;
  logic        req_d;

  assign req_i = mem_read_I | mem_write_I;
  assign req_d = mem_read_D | mem_write_D;

  // Next-state logic: arbitration in IDLE, completion handling in SERVE_x.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    case (state_q)
      IDLE: begin
        // mem_ready seen here belongs to nobody (e.g. survived a reset) and
        // is deliberately ignored.
        if (req_i && req_d) begin
          // Tie: grant the port that was not served last.
          if (last_q) begin
            state_d = SERVE_I;
          end else begin
            state_d = SERVE_D;
          end
        end else if (req_i) begin
          state_d = SERVE_I;
        end else if (req_d) begin
          state_d = SERVE_D;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        // A dropped request does not release the grant; only mem_ready does.
        if (mem_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
          cnt_i_d = sat_inc(cnt_i_q);
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          state_d = IDLE;
          last_d  = 1'b1;
          cnt_d_d = sat_inc(cnt_d_q);
        end else begin
          state_d = SERVE_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_i_q <= 16'd0;
      cnt_d_q <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  // Memory-side mux and ready steering for the granted port.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    mem_wdata   = {DATA_W{1'b0}};
    mem_ready_I = 1'b0;
    mem_ready_D = 1'b0;
    case (state_q)
      SERVE_I: begin
        // Write wins when a port asserts both read and write.
        mem_write   = mem_write_I;
        mem_read    = mem_read_I & ~mem_write_I;
        mem_addr    = mem_addr_I;
        mem_wdata   = mem_wdata_I;
        mem_ready_I = mem_ready;
      end
      SERVE_D: begin
        mem_write   = mem_write_D;
        mem_read    = mem_read_D & ~mem_write_D;
        mem_addr    = mem_addr_D;
        mem_wdata   = mem_wdata_D;
        mem_ready_D = mem_ready;
      end
      IDLE: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; each cache only samples it on its own ready.
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;

  assign grant_cnt_I = cnt_i_q;
  assign grant_cnt_D = cnt_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A behavioural model tracks which cache owns
// the memory, which cache was served last and how many transactions each has
// completed; a negedge monitor compares every DUT output against it. Directed
// sequences add hand-computed expectations (grant order, counts, async reset).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_I, mem_write_I;
  logic [AW-1:0] mem_addr_I;
  logic [DW-1:0] mem_wdata_I;
  logic [DW-1:0] mem_rdata_I;
  logic          mem_ready_I;
  logic          mem_read_D, mem_write_D;
  logic [AW-1:0] mem_addr_D;
  logic [DW-1:0] mem_wdata_D;
  logic [DW-1:0] mem_rdata_D;
  logic          mem_ready_D;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [15:0]   grant_cnt_I, grant_cnt_D;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I),
    .mem_addr_I(mem_addr_I), .mem_wdata_I(mem_wdata_I),
    .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D),
    .mem_addr_D(mem_addr_D), .mem_wdata_D(mem_wdata_D),
    .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_cnt_I(grant_cnt_I), .grant_cnt_D(grant_cnt_D)
  );

  always #5 clk = ~clk;

  int    n_pass  = 0;
  int    n_total = 0;
  string order   = "";

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = I-cache, 2 = D-cache
  int m_owner;
  bit m_last_d;
  int m_cnt_i, m_cnt_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner  <= 0;
      m_last_d <= 1'b0;
      m_cnt_i  <= 0;
      m_cnt_d  <= 0;
    end else if (m_owner == 0) begin
      if ((mem_read_I || mem_write_I) && (mem_read_D || mem_write_D))
        m_owner <= m_last_d ? 1 : 2;
      else if (mem_read_I || mem_write_I) m_owner <= 1;
      else if (mem_read_D || mem_write_D) m_owner <= 2;
    end else if (mem_ready) begin
      if (m_owner == 1) m_cnt_i <= (m_cnt_i < 65535) ? m_cnt_i + 1 : 65535;
      else              m_cnt_d <= (m_cnt_d < 65535) ? m_cnt_d + 1 : 65535;
      m_last_d <= (m_owner == 2);
      m_owner  <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic          e_rd, e_wr, e_rdy_i, e_rdy_d;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      if (m_owner == 1) begin
        e_wr = mem_write_I; e_rd = mem_read_I && !mem_write_I;
        e_addr = mem_addr_I; e_wdata = mem_wdata_I;
      end else if (m_owner == 2) begin
        e_wr = mem_write_D; e_rd = mem_read_D && !mem_write_D;
        e_addr = mem_addr_D; e_wdata = mem_wdata_D;
      end
      e_rdy_i = (m_owner == 1) && mem_ready;
      e_rdy_d = (m_owner == 2) && mem_ready;
      chk("cyc_mem_read",  mem_read,  e_rd);
      chk("cyc_mem_write", mem_write, e_wr);
      chk("cyc_ready_I",   mem_ready_I, e_rdy_i);
      chk("cyc_ready_D",   mem_ready_D, e_rdy_d);
      chk("cyc_rdata_I",   mem_rdata_I, mem_rdata);
      chk("cyc_rdata_D",   mem_rdata_D, mem_rdata);
      chk("cyc_cnt_I",     grant_cnt_I, m_cnt_i[15:0]);
      chk("cyc_cnt_D",     grant_cnt_D, m_cnt_d[15:0]);
      if (m_owner != 0) begin
        chk("cyc_mem_addr",  mem_addr,  e_addr);
        chk("cyc_mem_wdata", mem_wdata, e_wdata);
      end
      if (mem_ready_I) order = {order, "I"};
      if (mem_ready_D) order = {order, "D"};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_I = 1'b0; mem_write_I = 1'b0; mem_addr_I = '0; mem_wdata_I = '0;
    mem_read_D = 1'b0; mem_write_D = 1'b0; mem_addr_D = '0; mem_wdata_D = '0;
    mem_rdata = '0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Memory responder: wait (bounded) for a request, then complete it after
  // lat cycles with a one-cycle ready pulse and random read data.
  task automatic respond(input int lat);
    int k = 0;
    while (!(mem_read || mem_write) && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      chk("req_timeout", 1'b0, 1'b1);
    end else begin
      repeat (lat) tick();
      mem_ready = 1'b1;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      mem_ready = 1'b0;
      chk("idle_bubble", {mem_read, mem_write}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_cnt_I", grant_cnt_I, 16'd0);

    // ---- async reset with random inputs, port D guaranteed to request ----
    mem_read_I  = 1'($urandom); mem_write_I = 1'($urandom);
    mem_addr_I  = AW'($urandom); mem_wdata_I = {$urandom, $urandom, $urandom, $urandom};
    mem_read_D  = 1'($urandom); mem_write_D = 1'b1;
    mem_addr_D  = AW'($urandom); mem_wdata_D = {$urandom, $urandom, $urandom, $urandom};
    tick();
    chk("rand_granted", mem_write | mem_read, 1'b1);
    mem_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_mem_read",  mem_read,  1'b0);
    chk("async_mem_write", mem_write, 1'b0);
    chk("async_ready_I",   mem_ready_I, 1'b0);
    chk("async_ready_D",   mem_ready_D, 1'b0);
    chk("async_cnt_I",     grant_cnt_I, 16'd0);
    chk("async_cnt_D",     grant_cnt_D, 16'd0);
    clear_inputs();
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    // mem_ready held high in IDLE must not reach either cache
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready_I", mem_ready_I, 1'b0);
      chk("idle_ready_D", mem_ready_D, 1'b0);
    end
    mem_ready = 1'b0;
    tick();

    // ---- single I read ----
    mem_read_I = 1'b1; mem_addr_I = 28'h0000010;
    tick();
    chk("i_read_fwd", mem_read, 1'b1);
    chk("i_addr_fwd", mem_addr, 28'h0000010);
    mem_ready = 1'b1;
    mem_rdata = {4{32'hDEADBEEF}};
    #1;
    chk("i_ready",   mem_ready_I, 1'b1);
    chk("i_ready_D", mem_ready_D, 1'b0);
    chk("i_rdata",   mem_rdata_I, {4{32'hDEADBEEF}});
    tick();
    mem_ready = 1'b0; mem_read_I = 1'b0;
    chk("i_ready_pulse", mem_ready_I, 1'b0);
    chk("i_cnt", grant_cnt_I, 16'd1);
    tick();

    // ---- tie after reset: D first, one idle cycle, then I ----
    do_reset();
    order = "";
    mem_read_I  = 1'b1; mem_addr_I = 28'h0000030;
    mem_write_D = 1'b1; mem_addr_D = 28'h0000020; mem_wdata_D = 128'h1234;
    tick();
    chk("tie_write", mem_write, 1'b1);
    chk("tie_read",  mem_read,  1'b0);
    chk("tie_wdata", mem_wdata, 128'h1234);
    chk("tie_addr",  mem_addr,  28'h0000020);
    respond(1);
    mem_write_D = 1'b0;
    tick();
    chk("tie_i_read", mem_read, 1'b1);
    chk("tie_i_addr", mem_addr, 28'h0000030);
    respond(2);
    mem_read_I = 1'b0;
    tick();
    chk_s("tie_order", order, "DI");

    // ---- sustained contention: 8 transactions ----
    do_reset();
    order = "";
    mem_read_I = 1'b1; mem_addr_I = 28'h0000040;
    mem_read_D = 1'b1; mem_addr_D = 28'h0000050;
    for (int t = 0; t < 8; t++) respond(2);
    mem_read_I = 1'b0; mem_read_D = 1'b0;
    tick();
    chk_s("rr_order", order, "DIDIDIDI");
    chk("rr_cnt_I", grant_cnt_I, 16'd4);
    chk("rr_cnt_D", grant_cnt_D, 16'd4);

    // ---- reset mid-transaction, stale ready afterwards ----
    do_reset();
    mem_read_D = 1'b1; mem_addr_D = 28'h0000060;
    tick();
    chk("mid_serve_D", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    mem_read_D = 1'b0;
    #1;
    chk("mid_async_read", mem_read, 1'b0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("stale_ready_D", mem_ready_D, 1'b0);
    chk("stale_ready_I", mem_ready_I, 1'b0);
    tick();
    mem_ready = 1'b0;
    chk("stale_idle", {mem_read, mem_write}, 2'b00);
    chk("stale_cnt_D", grant_cnt_D, 16'd0);
    mem_read_I = 1'b1; mem_addr_I = 28'h0000070;
    respond(1);
    mem_read_I = 1'b0;
    tick();
    chk("post_rst_cnt_I", grant_cnt_I, 16'd1);

    // ---- write-over-read masking ----
    mem_read_D = 1'b1; mem_write_D = 1'b1;
    mem_addr_D = 28'h0000080; mem_wdata_D = 128'hA5A5;
    tick();
    chk("mask_write", mem_write, 1'b1);
    chk("mask_read",  mem_read,  1'b0);
    respond(3);
    mem_read_D = 1'b0; mem_write_D = 1'b0;
    tick();
    chk("mask_cnt_D", grant_cnt_D, 16'd1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
